// File: rtl/arbitro_escritura_banco.sv
// Write-port arbiter and RAW hazard scoreboard for the 32x32 MIPS register file.
// Round-robin between ALU (A) and load (M) write-back, with one-cycle registered write port.
module arbitro_escritura_banco #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              m_valid,
    input  logic [ADDR_W-1:0] m_reg,
    input  logic [DATA_W-1:0] m_data,
    output logic              m_ready,
    input  logic              hold,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_reg,
    input  logic [ADDR_W-1:0] q_reg1,
    input  logic [ADDR_W-1:0] q_reg2,
    output logic              hazard,
    output logic [ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
    output logic              Regwrite,
    output logic [1:0]        err
);

    localparam int NREG = 2 ** ADDR_W;

    typedef enum logic {PREF_A, PREF_M} prefT;

    prefT              pointer;
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busyNext;
    logic              grant;
    logic [ADDR_W-1:0] grantReg;
    logic [DATA_W-1:0] grantData;
    logic [1:0]        errNext;

    assign a_ready = !reset && !hold && a_valid && (!m_valid || pointer == PREF_A);
    assign m_ready = !reset && !hold && m_valid && (!a_valid || pointer == PREF_M);
    assign grant   = a_ready || m_ready;
    assign hazard  = busy[q_reg1] | busy[q_reg2];

    always_comb begin
        grantReg  = m_reg;
        grantData = m_data;
        if (a_ready) begin
            grantReg  = a_reg;
            grantData = a_data;
        end
    end

    // Clear is applied before set so a new reservation replaces the retiring producer.
    always_comb begin
        busyNext = busy;
        if (grant && grantReg != '0) begin
            busyNext[grantReg] = 1'b0;
        end
        if (rsv_valid && rsv_reg != '0) begin
            busyNext[rsv_reg] = 1'b1;
        end
        busyNext[0] = 1'b0;
    end

    always_comb begin
        errNext = err;
        if (rsv_valid && rsv_reg != '0 && busy[rsv_reg] && !(grant && grantReg == rsv_reg)) begin
            errNext[0] = 1'b1;
        end
        if (grant && grantReg != '0 && !busy[grantReg]) begin
            errNext[1] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pointer   <= PREF_A;
            busy      <= '0;
            err       <= 2'b00;
            WriteReg  <= '0;
            WriteData <= '0;
            Regwrite  <= 1'b0;
        end else begin
            busy     <= busyNext;
            err      <= errNext;
            Regwrite <= 1'b0;
            if (grant) begin
                pointer   <= a_ready ? PREF_M : PREF_A;
                WriteReg  <= grantReg;
                WriteData <= grantData;
                Regwrite  <= (grantReg != '0);
            end
        end
    end

endmodule

// File: tb/tb_arbitro_escritura_banco.sv
// Directed table-driven bench for arbitro_escritura_banco plus hand-written reset/hold sequences.
module tb_arbitro_escritura_banco;

    logic        clk;
    logic        reset;
    logic        a_valid;
    logic [4:0]  a_reg;
    logic [31:0] a_data;
    logic        a_ready;
    logic        m_valid;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    logic        m_ready;
    logic        hold;
    logic        rsv_valid;
    logic [4:0]  rsv_reg;
    logic [4:0]  q_reg1;
    logic [4:0]  q_reg2;
    logic        hazard;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic        Regwrite;
    logic [1:0]  err;

    int testsRun;
    int failures;

    arbitro_escritura_banco #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
        .m_valid(m_valid), .m_reg(m_reg), .m_data(m_data), .m_ready(m_ready),
        .hold(hold), .rsv_valid(rsv_valid), .rsv_reg(rsv_reg),
        .q_reg1(q_reg1), .q_reg2(q_reg2), .hazard(hazard),
        .WriteReg(WriteReg), .WriteData(WriteData), .Regwrite(Regwrite), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mr;
        logic [31:0] md;
        logic        hld;
        logic        rv;
        logic [4:0]  rr;
        logic [4:0]  q1;
        logic [4:0]  q2;
        logic        eAr;
        logic        eMr;
        logic        eHaz;
        logic        eRw;
        logic        chkW;
        logic [4:0]  eWr;
        logic [31:0] eWd;
        logic [1:0]  eErr;
    } vecT;

    vecT vecs[26];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic setIdle();
        reset = 1'b0; a_valid = 1'b0; a_reg = '0; a_data = '0;
        m_valid = 1'b0; m_reg = '0; m_data = '0; hold = 1'b0;
        rsv_valid = 1'b0; rsv_reg = '0; q_reg1 = '0; q_reg2 = '0;
    endtask

    task automatic applyStimulus(input vecT v);
        reset = v.rst; a_valid = v.av; a_reg = v.ar; a_data = v.ad;
        m_valid = v.mv; m_reg = v.mr; m_data = v.md; hold = v.hld;
        rsv_valid = v.rv; rsv_reg = v.rr; q_reg1 = v.q1; q_reg2 = v.q2;
    endtask

    task automatic checkOutput(input vecT v, input int idx);
        @(posedge clk);
        #1;
        check($sformatf("v%0d Regwrite", idx), 32'(Regwrite), 32'(v.eRw));
        check($sformatf("v%0d err", idx), 32'(err), 32'(v.eErr));
        if (v.chkW) begin
            check($sformatf("v%0d WriteReg", idx), 32'(WriteReg), 32'(v.eWr));
            check($sformatf("v%0d WriteData", idx), WriteData, v.eWd);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        setIdle();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        testsRun = 0;
        failures = 0;
        setIdle();
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // Reset with a pending request, then reserve and retire reg 5.
        vecs[0]  = '{rst:1, av:1, ar:5, chkW:1, default:'0};
        vecs[1]  = '{rv:1, rr:5, q1:5, chkW:1, default:'0};
        vecs[2]  = '{av:1, ar:5, ad:32'hDEADBEEF, q1:5, eAr:1, eHaz:1, eRw:1, chkW:1, eWr:5, eWd:32'hDEADBEEF, default:'0};
        vecs[3]  = '{q1:5, chkW:1, eWr:5, eWd:32'hDEADBEEF, default:'0};
        vecs[4]  = '{rv:1, rr:3, chkW:1, eWr:5, eWd:32'hDEADBEEF, default:'0};
        vecs[5]  = '{rv:1, rr:4, chkW:1, eWr:5, eWd:32'hDEADBEEF, default:'0};
        // Both valid with pointer at M; each grant re-reserved in the same cycle (set wins).
        vecs[6]  = '{av:1, ar:3, ad:32'h33, mv:1, mr:4, md:32'h44, rv:1, rr:4, q1:3, q2:4, eMr:1, eHaz:1, eRw:1, chkW:1, eWr:4, eWd:32'h44, default:'0};
        vecs[7]  = '{av:1, ar:3, ad:32'h33, mv:1, mr:4, md:32'h44, rv:1, rr:3, q1:3, q2:4, eAr:1, eHaz:1, eRw:1, chkW:1, eWr:3, eWd:32'h33, default:'0};
        vecs[8]  = '{av:1, ar:3, ad:32'h33, mv:1, mr:4, md:32'h44, rv:1, rr:4, q1:3, q2:4, eMr:1, eHaz:1, eRw:1, chkW:1, eWr:4, eWd:32'h44, default:'0};
        vecs[9]  = '{av:1, ar:3, ad:32'h33, mv:1, mr:4, md:32'h44, rv:1, rr:3, q1:3, q2:4, eAr:1, eHaz:1, eRw:1, chkW:1, eWr:3, eWd:32'h33, default:'0};
        vecs[10] = '{mv:1, mr:3, md:32'h55, q1:3, eMr:1, eHaz:1, eRw:1, chkW:1, eWr:3, eWd:32'h55, default:'0};
        vecs[11] = '{mv:1, mr:4, md:32'h66, q1:3, eMr:1, eRw:1, chkW:1, eWr:4, eWd:32'h66, default:'0};
        // Reservation of reg 8 becomes visible one cycle later and drops after the load retires.
        vecs[12] = '{rv:1, rr:8, q2:8, chkW:1, eWr:4, eWd:32'h66, default:'0};
        vecs[13] = '{q2:8, eHaz:1, chkW:1, eWr:4, eWd:32'h66, default:'0};
        vecs[14] = '{mv:1, mr:8, md:32'h88, q2:8, eMr:1, eHaz:1, eRw:1, chkW:1, eWr:8, eWd:32'h88, default:'0};
        vecs[15] = '{q2:8, chkW:1, eWr:8, eWd:32'h88, default:'0};
        // Reg 0 write is accepted silently; unreserved reg 7 raises sticky err[1].
        vecs[16] = '{av:1, ar:0, ad:32'h1, eAr:1, default:'0};
        vecs[17] = '{default:'0};
        vecs[18] = '{av:1, ar:7, ad:32'h77, eAr:1, eRw:1, chkW:1, eWr:7, eWd:32'h77, eErr:2'b10, default:'0};
        vecs[19] = '{chkW:1, eWr:7, eWd:32'h77, eErr:2'b10, default:'0};
        vecs[20] = '{rv:1, rr:10, chkW:1, eWr:7, eWd:32'h77, eErr:2'b10, default:'0};
        vecs[21] = '{rv:1, rr:10, chkW:1, eWr:7, eWd:32'h77, eErr:2'b11, default:'0};
        vecs[22] = '{rst:1, chkW:1, default:'0};
        // Hold blocks the grant but the scoreboard still answers.
        vecs[23] = '{rv:1, rr:12, chkW:1, default:'0};
        vecs[24] = '{hld:1, av:1, ar:12, ad:32'hC, q1:12, eHaz:1, chkW:1, default:'0};
        vecs[25] = '{av:1, ar:12, ad:32'hC, q1:12, eAr:1, eHaz:1, eRw:1, chkW:1, eWr:12, eWd:32'hC, default:'0};

        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            check($sformatf("v%0d a_ready", i), 32'(a_ready), 32'(vecs[i].eAr));
            check($sformatf("v%0d m_ready", i), 32'(m_ready), 32'(vecs[i].eMr));
            check($sformatf("v%0d hazard", i), 32'(hazard), 32'(vecs[i].eHaz));
            checkOutput(vecs[i], i);
        end

        // Grant followed immediately by reset: pending write dropped, pointer back to A.
        doReset();
        rsv_valid = 1'b1; rsv_reg = 5'd3;
        @(negedge clk);
        rsv_reg = 5'd4;
        @(negedge clk);
        rsv_valid = 1'b0;
        a_valid = 1'b1; a_reg = 5'd3; a_data = 32'hA3;
        m_valid = 1'b1; m_reg = 5'd4; m_data = 32'hB4;
        #1;
        check("rst_seq first grant a_ready", 32'(a_ready), 32'd1);
        check("rst_seq first grant m_ready", 32'(m_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_seq a_ready under reset", 32'(a_ready), 32'd0);
        check("rst_seq m_ready under reset", 32'(m_ready), 32'd0);
        @(posedge clk);
        #1;
        check("rst_seq Regwrite after reset", 32'(Regwrite), 32'd0);
        check("rst_seq WriteReg after reset", 32'(WriteReg), 32'd0);
        @(negedge clk);
        reset = 1'b0; q_reg1 = 5'd3; q_reg2 = 5'd4;
        #1;
        check("rst_seq hazard cleared", 32'(hazard), 32'd0);
        check("rst_seq pointer at A", 32'(a_ready), 32'd1);
        @(posedge clk);
        #1;
        check("rst_seq WriteReg", 32'(WriteReg), 32'd3);
        check("rst_seq Regwrite", 32'(Regwrite), 32'd1);

        // Hold for three cycles with both requesting; pointer is left at M.
        doReset();
        rsv_valid = 1'b1; rsv_reg = 5'd6;
        @(negedge clk);
        rsv_valid = 1'b0;
        a_valid = 1'b1; a_reg = 5'd6; a_data = 32'h66;
        @(negedge clk);
        a_data = 32'h600;
        m_valid = 1'b1; m_reg = 5'd9; m_data = 32'h99;
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("hold c%0d a_ready", k), 32'(a_ready), 32'd0);
            check($sformatf("hold c%0d m_ready", k), 32'(m_ready), 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("hold c%0d Regwrite", k), 32'(Regwrite), 32'd0);
            check($sformatf("hold c%0d WriteReg", k), 32'(WriteReg), 32'd6);
            @(negedge clk);
        end
        hold = 1'b0;
        #1;
        check("hold release m_ready", 32'(m_ready), 32'd1);
        check("hold release a_ready", 32'(a_ready), 32'd0);
        @(posedge clk);
        #1;
        check("hold release Regwrite", 32'(Regwrite), 32'd1);
        check("hold release WriteReg", 32'(WriteReg), 32'd9);
        check("hold release WriteData", WriteData, 32'h99);

        @(negedge clk);
        setIdle();
        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule

// File: doc/arbitro_escritura_banco.md
Name: arbitro_escritura_banco

Overview:
Write-port arbiter and hazard scoreboard for the 32x32 register file in the multicycle MIPS datapath. It shares the register file's single write port between two write-back requesters: A (ALU result) and M (load data from memory). It tracks which registers have a write still outstanding so decode can stall on RAW hazards. It drives WriteReg, WriteData and Regwrite of the register file directly.

Parameters:
DATA_W, 32, write data width
ADDR_W, 5, register index width (2**ADDR_W registers)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
a_valid  input  1  ALU write-back request
a_reg  input  ADDR_W  ALU destination register
a_data  input  DATA_W  ALU result
a_ready  output  1  ALU request accepted this cycle
m_valid  input  1  load write-back request
m_reg  input  ADDR_W  load destination register
m_data  input  DATA_W  load data
m_ready  output  1  load request accepted this cycle
hold  input  1  freeze arbitration; no grants while high
rsv_valid  input  1  decode issues an instruction that will write rsv_reg
rsv_reg  input  ADDR_W  register being reserved
q_reg1  input  ADDR_W  decode source register 1 (rs)
q_reg2  input  ADDR_W  decode source register 2 (rt)
hazard  output  1  q_reg1 or q_reg2 has an outstanding write
WriteReg  output  ADDR_W  to register file
WriteData  output  DATA_W  to register file
Regwrite  output  1  to register file, one-cycle pulse per write
err  output  2  sticky: bit0 duplicate reservation, bit1 unreserved write

Behaviour:
- Reset (sampled on clk when reset=1): WriteReg=0, WriteData=0, Regwrite=0, err=2'b00, all busy bits=0, round-robin pointer=0 (A preferred). Reset overrides every other input in the same cycle. An accepted write pending on the output is dropped: Regwrite=0 in the cycle after reset.
- Handshake: a request transfers when valid&&ready. a_ready and m_ready are combinational from the valid inputs, hold and the pointer. At most one is high per cycle. Both are 0 when hold=1 or reset=1.
- Arbitration:
  - Only one valid: grant it.
  - Both valid: grant A if pointer=0, otherwise M.
  - After every grant, the pointer points at the other requester. With no grant, the pointer is unchanged.
  - A requester that is not granted must keep valid, reg and data stable until it is granted.
- Output latency is 1 cycle. If a grant occurs in cycle N, then in cycle N+1 WriteReg and WriteData hold the granted reg/data and Regwrite=1.
- With no grant, Regwrite=0 and WriteReg/WriteData keep their last values.
- Register 0: a granted write to reg 0 is accepted (ready=1) but produces Regwrite=0. It does not touch the scoreboard.
- Scoreboard: one busy bit per register. busy[0] is constant 0.
  - Set: rsv_valid=1 and rsv_reg!=0 sets busy[rsv_reg] at the next edge.
  - Clear: a grant with reg!=0 clears busy[reg] at the next edge.
  - Set and clear of the same register in one cycle: set wins (a new producer replaces the old one).
- hazard = busy[q_reg1] | busy[q_reg2]. It is combinational from the registered busy bits only. A reservation made in cycle N is visible to hazard from cycle N+1.
- Error flags, both sticky until reset:
  - err[0] sets when rsv_valid targets an already-busy register that is not cleared in the same cycle.
  - err[1] sets when a granted write (reg!=0) targets a register whose busy bit is 0.
  - Neither flag changes the data path.
- hold=1: no grants, pointer and output registers unchanged, Regwrite=0. Reservations and the scoreboard still update.

Test Plan:
- Reset, then a_valid with a_reg=5, a_data=32'hDEAD_BEEF, reserved beforehand → a_ready=1 in cycle N; cycle N+1 shows WriteReg=5, WriteData=32'hDEADBEEF, Regwrite=1; busy[5] cleared; hazard for q_reg1=5 drops in cycle N+1.
- a_valid and m_valid held high for 4 cycles (regs 3 and 4) → grant order A, M, A, M; Regwrite high for 4 consecutive cycles, WriteReg sequence 3, 4, 3, 4.
- rsv_reg=8 in cycle N and q_reg2=8 → hazard=0 in cycle N, 1 in cycle N+1; it stays 1 until m write to reg 8 is granted, then 0 in the cycle after the grant.
- Same-cycle rsv_reg=9 and granted write to reg 9 (busy[9]=1) → busy[9] remains 1 and err stays 00.
- Write to reg 0 with a_data=32'h1 → a_ready=1, Regwrite stays 0, err stays 00. Then a write to unreserved reg 7 → Regwrite=1 and err[1]=1, sticky until reset.
- Grant in cycle N with reset asserted in cycle N+1 (and hold=1 in a separate run) → Regwrite=0 after reset, all busy bits cleared, pointer back to A. Under hold, no ready is asserted for 3 cycles and grants resume in the cycle hold falls.
